// File: rtl/sram_ctrl.sv
// sram_ctrl: serves one 32-bit word request at a time as low/high halfword accesses on a 16-bit async SRAM.
// Each access is 1 setup + WAIT_CYCLES strobe cycles; write halves with no enabled bytes are skipped.
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wren,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_bmask,
  output logic              o_rsp_vld,
  output logic [31:0]       o_rsp_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-2:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q, bmask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;

  logic active;
  logic in_hi;
  logic strobe;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{i_req_addr[31:ADDR_W+1], i_req_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wren_d      = wren_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    bmask_d     = bmask_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_vld) begin
          wren_d  = i_req_wren;
          waddr_d = i_req_addr[ADDR_W:2];
          wdata_d = i_req_wdata;
          bmask_d = i_req_bmask;
          cnt_d   = '0;
          // Address is set up at the accept edge so it is valid in the first setup cycle.
          if (!i_req_wren || (|i_req_bmask[1:0])) begin
            state_d     = S_LO;
            sram_addr_d = {i_req_addr[ADDR_W:2], 1'b0};
          end else if (|i_req_bmask[3:2]) begin
            state_d     = S_HI;
            sram_addr_d = {i_req_addr[ADDR_W:2], 1'b1};
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_LO: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!wren_q) rdata_d[15:0] = io_sram_dq;
          if (wren_q && (bmask_q[3:2] == 2'b00)) begin
            state_d = S_RESP;
          end else begin
            state_d     = S_HI;
            sram_addr_d = {waddr_q, 1'b1};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RESP;
          if (!wren_q) rdata_d[31:16] = io_sram_dq;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  // Pin controls decode straight from state so an async reset releases the bus at once.
  assign active = (state_q == S_LO) || (state_q == S_HI);
  assign in_hi  = (state_q == S_HI);
  assign strobe = (cnt_q != '0);

  assign o_req_rdy   = (state_q == S_IDLE);
  assign o_rsp_vld   = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_sram_addr = sram_addr_q;

  assign o_sram_ce_n = !active;
  assign o_sram_oe_n = !(active && !wren_q);
  assign o_sram_we_n = !(active && wren_q && strobe);
  assign o_sram_lb_n = active ? (wren_q ? ~(in_hi ? bmask_q[2] : bmask_q[0]) : 1'b0) : 1'b1;
  assign o_sram_ub_n = active ? (wren_q ? ~(in_hi ? bmask_q[3] : bmask_q[1]) : 1'b0) : 1'b1;

  assign io_sram_dq = (active && wren_q) ? (in_hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: board SRAM model on the data pins plus a byte-level reference memory.
module tb_sram_ctrl;

  localparam int ADDR_W = 18;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_req_vld = 1'b0;
  logic              o_req_rdy;
  logic              i_req_wren = 1'b0;
  logic [31:0]       i_req_addr = '0;
  logic [31:0]       i_req_wdata = '0;
  logic [3:0]        i_req_bmask = '0;
  logic              o_rsp_vld;
  logic [31:0]       o_rsp_rdata;
  logic [ADDR_W-1:0] sram_addr;
  wire  [15:0]       sram_dq;
  logic              ce_n, oe_n, we_n, lb_n, ub_n;

  int checks = 0;
  int passed = 0;

  logic [15:0] sram [0:1023] = '{default: 16'h0000};
  logic [7:0]  ref_b [0:2047] = '{default: 8'h00};
  logic [31:0] last_rd = '0;

  int ce_cnt = 0, we_cnt = 0, rsp_cnt = 0;
  logic we_lb = 1'b1, we_ub = 1'b1;
  logic [ADDR_W-1:0] we_addr = '0;

  sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wren(i_req_wren),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_bmask(i_req_bmask),
    .o_rsp_vld(o_rsp_vld), .o_rsp_rdata(o_rsp_rdata),
    .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  always #5 i_clk = ~i_clk;

  // Board SRAM: drives the bus on output-enabled reads, latches enabled bytes while we_n is low.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge i_clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) sram[sram_addr[9:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge i_clk) begin
    if (!ce_n) ce_cnt++;
    if (!we_n) begin
      we_cnt++;
      we_lb = lb_n;
      we_ub = ub_n;
      we_addr = sram_addr;
    end
    if (o_rsp_vld) rsp_cnt++;
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_b[{a[10:2], 2'd3}], ref_b[{a[10:2], 2'd2}], ref_b[{a[10:2], 2'd1}], ref_b[{a[10:2], 2'd0}]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm);
    for (int n = 0; n < 4; n++)
      if (bm[n]) ref_b[{a[10:2], 2'(n)}] = wd[8*n +: 8];
  endtask

  // Issues one request and waits for its response; lat is edges from accept to the response cycle.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm,
                        output int lat, output logic [31:0] rd, output int dce, output int dwe);
    int g;
    int ce0, we0;
    logic [31:0] junk;
    @(negedge i_clk); #1;
    g = 0;
    while (!o_req_rdy && g < 50) begin
      @(negedge i_clk); #1;
      g++;
    end
    ce0 = ce_cnt; we0 = we_cnt;
    i_req_vld = 1'b1; i_req_wren = wr; i_req_addr = a; i_req_wdata = wd; i_req_bmask = bm;
    @(posedge i_clk); #1;
    junk = $urandom();
    i_req_vld = 1'b0; i_req_wren = junk[0]; i_req_addr = $urandom(); i_req_wdata = $urandom();
    i_req_bmask = junk[7:4];
    lat = -1; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk); #1;
      if (o_rsp_vld) begin
        lat = k;
        rd = o_rsp_rdata;
        break;
      end
    end
    dce = ce_cnt - ce0; dwe = we_cnt - we0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if (o_req_rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", o_req_rdy); else passed++;
    checks++; if (o_rsp_vld !== 1'b0) $display("FAIL reset_rsp_vld got %b want 0", o_rsp_vld); else passed++;
    checks++; if (o_rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", o_rsp_rdata); else passed++;
    checks++; if (sram_addr !== '0) $display("FAIL reset_addr got %h want 0", sram_addr); else passed++;
    checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'h1F)
      $display("FAIL reset_strobes got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); else passed++;
    i_rstn = 1'b1;
  endtask

  task automatic test_write_full;
    int lat, dce, dwe; logic [31:0] rd;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, dce, dwe);
    ref_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (lat !== 4) $display("FAIL wr_full_latency got %0d want 4", lat); else passed++;
    checks++; if (dwe !== 2) $display("FAIL wr_full_we_cycles got %0d want 2", dwe); else passed++;
    checks++; if (sram[8] !== 16'hBEEF) $display("FAIL wr_full_sram8 got %h want beef", sram[8]); else passed++;
    checks++; if (sram[9] !== 16'hDEAD) $display("FAIL wr_full_sram9 got %h want dead", sram[9]); else passed++;
    checks++; if (rd !== last_rd) $display("FAIL wr_full_rdata_hold got %h want %h", rd, last_rd); else passed++;
  endtask

  task automatic test_read;
    int lat, dce, dwe; logic [31:0] rd;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, dce, dwe);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd); else passed++;
    checks++; if (lat !== 4) $display("FAIL rd_latency got %0d want 4", lat); else passed++;
    checks++; if (dwe !== 0) $display("FAIL rd_we_cycles got %0d want 0", dwe); else passed++;
    last_rd = rd;
  endtask

  task automatic test_partial;
    int lat, dce, dwe; logic [31:0] rd;
    do_req(1'b1, 32'h10, 32'h00AA0000, 4'b0100, lat, rd, dce, dwe);
    ref_write(32'h10, 32'h00AA0000, 4'b0100);
    checks++; if (lat !== 2) $display("FAIL part_latency got %0d want 2", lat); else passed++;
    checks++; if (dwe !== 1) $display("FAIL part_we_cycles got %0d want 1", dwe); else passed++;
    checks++; if ({we_lb, we_ub} !== 2'b01) $display("FAIL part_lb_ub got %b want 01", {we_lb, we_ub}); else passed++;
    checks++; if (we_addr !== 18'd9) $display("FAIL part_addr got %h want 9", we_addr); else passed++;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, dce, dwe);
    checks++; if (rd !== 32'hDEAABEEF) $display("FAIL part_readback got %h want deaabeef", rd); else passed++;
    last_rd = rd;
  endtask

  task automatic test_zero_mask;
    int lat, dce, dwe; logic [31:0] rd;
    logic [15:0] s8, s9;
    s8 = sram[8]; s9 = sram[9];
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rd, dce, dwe);
    checks++; if (lat !== 0) $display("FAIL zero_latency got %0d want 0", lat); else passed++;
    checks++; if (dce !== 0) $display("FAIL zero_ce_cycles got %0d want 0", dce); else passed++;
    checks++; if ({sram[9], sram[8]} !== {s9, s8})
      $display("FAIL zero_sram got %h want %h", {sram[9], sram[8]}, {s9, s8}); else passed++;
    checks++; if (rd !== last_rd) $display("FAIL zero_rdata_hold got %h want %h", rd, last_rd); else passed++;
  endtask

  task automatic test_back_to_back;
    int acc, nrsp, busy, first_rsp, sec_acc;
    logic [31:0] rd1, rd2;
    acc = 0; nrsp = 0; busy = 0; first_rsp = -1; sec_acc = -1; rd1 = '0; rd2 = '0;
    @(negedge i_clk); #1;
    i_req_wren = 1'b0; i_req_addr = 32'h10; i_req_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (o_rsp_vld) begin
        nrsp++;
        if (nrsp == 1) begin first_rsp = c; rd1 = o_rsp_rdata; end
        else rd2 = o_rsp_rdata;
      end
      if (acc == 1 && !o_req_rdy) busy++;
      if (o_req_rdy && i_req_vld) begin
        acc++;
        if (acc == 2) sec_acc = c;
        @(posedge i_clk); #1;
        if (acc == 1) i_req_addr = 32'h14;
        else i_req_vld = 1'b0;
      end
      @(negedge i_clk); #1;
    end
    i_req_vld = 1'b0;
    checks++; if (acc !== 2) $display("FAIL b2b_accepts got %0d want 2", acc); else passed++;
    checks++; if (busy !== 5) $display("FAIL b2b_rdy_low_cycles got %0d want 5", busy); else passed++;
    checks++; if (sec_acc !== first_rsp + 1)
      $display("FAIL b2b_second_accept got cycle %0d want %0d", sec_acc, first_rsp + 1); else passed++;
    checks++; if (nrsp !== 2) $display("FAIL b2b_rsp_count got %0d want 2", nrsp); else passed++;
    checks++; if (rd1 !== ref_word(32'h10)) $display("FAIL b2b_rd1 got %h want %h", rd1, ref_word(32'h10)); else passed++;
    checks++; if (rd2 !== ref_word(32'h14)) $display("FAIL b2b_rd2 got %h want %h", rd2, ref_word(32'h14)); else passed++;
    last_rd = rd2;
  endtask

  task automatic test_random;
    int lat, dce, dwe, halves, exp_lat;
    logic [31:0] rd, r, ra, a, wd;
    logic wr; logic [3:0] bm;
    for (int i = 0; i < 40; i++) begin
      r = $urandom(); ra = $urandom(); wd = $urandom();
      wr = r[0]; bm = r[7:4];
      a = {ra[31:19], 8'h00, ra[10:0]};
      halves = wr ? (int'(|bm[1:0]) + int'(|bm[3:2])) : 2;
      exp_lat = 2 * halves;
      do_req(wr, a, wd, bm, lat, rd, dce, dwe);
      checks++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, exp_lat); else passed++;
      checks++; if (dce !== 2 * halves) $display("FAIL rand_ce_cycles[%0d] got %0d want %0d", i, dce, 2 * halves); else passed++;
      checks++; if (dwe !== (wr ? halves : 0))
        $display("FAIL rand_we_cycles[%0d] got %0d want %0d", i, dwe, wr ? halves : 0); else passed++;
      if (wr) begin
        checks++; if (rd !== last_rd) $display("FAIL rand_rdata_hold[%0d] got %h want %h", i, rd, last_rd); else passed++;
        ref_write(a, wd, bm);
      end else begin
        checks++; if (rd !== ref_word(a)) $display("FAIL rand_read[%0d] got %h want %h", i, rd, ref_word(a)); else passed++;
        last_rd = rd;
      end
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, dce, dwe, rsp0; logic [31:0] rd, d; logic [15:0] old_hi;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, dce, dwe);
    ref_write(32'h20, 32'h11223344, 4'hF);
    old_hi = sram[17];
    d = $urandom();
    @(negedge i_clk); #1;
    i_req_vld = 1'b1; i_req_wren = 1'b1; i_req_addr = 32'h20; i_req_wdata = d; i_req_bmask = 4'hF;
    @(posedge i_clk); #1;
    i_req_vld = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    ref_write(32'h20, d, 4'b0011);
    checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'h1F)
      $display("FAIL mid_rst_strobes got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); else passed++;
    checks++; if (o_rsp_vld !== 1'b0) $display("FAIL mid_rst_rsp_vld got %b want 0", o_rsp_vld); else passed++;
    checks++; if (sram_addr !== '0) $display("FAIL mid_rst_addr got %h want 0", sram_addr); else passed++;
    checks++; if (o_rsp_rdata !== 32'h0) $display("FAIL mid_rst_rdata got %h want 0", o_rsp_rdata); else passed++;
    checks++; if (sram[17] !== old_hi) $display("FAIL mid_rst_sram17 got %h want %h", sram[17], old_hi); else passed++;
    last_rd = '0;
    rsp0 = rsp_cnt;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (10) @(negedge i_clk);
    #1;
    checks++; if (rsp_cnt !== rsp0) $display("FAIL mid_rst_no_rsp got %0d want %0d", rsp_cnt, rsp0); else passed++;
    checks++; if (o_req_rdy !== 1'b1) $display("FAIL mid_rst_rdy got %b want 1", o_req_rdy); else passed++;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, dce, dwe);
    checks++; if (rd !== ref_word(32'h20)) $display("FAIL mid_rst_readback got %h want %h", rd, ref_word(32'h20)); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_read();
    test_partial();
    test_zero_mask();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
